// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants, grid geometry, cell codes and cell-to-channel mapping
package vga_pkg;
  localparam int COLOR_W = 4;
  localparam int GRID_W = 64;
  localparam int GRID_H = 48;
  localparam int CELL_PX = 10;
  localparam int H_VIS = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_VIS = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_FOOD = 2'b01;
  localparam logic [1:0] CELL_SNAKE = 2'b10;
  localparam logic [1:0] CELL_WALL = 2'b11;
  function automatic logic [2:0] cell_mask(input logic [1:0] code);
    return code == CELL_EMPTY ? 3'b000 : code == CELL_FOOD ? 3'b100 : code == CELL_SNAKE ? 3'b010 : 3'b001;
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: clk/reset in; pix_en, cell_x/cell_y, raw hs/vs, visible flag and snapshot strobe out
module vga_timing_gen #(
  parameter int CELL_PX = vga_pkg::CELL_PX,
  parameter int GRID_W = vga_pkg::GRID_W,
  parameter int GRID_H = vga_pkg::GRID_H,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP,
  parameter int CXW = $clog2(GRID_W),
  parameter int CYW = $clog2(GRID_H)
) (
  input  logic           clk,
  input  logic           reset,
  output logic           pix_en,
  output logic [CXW-1:0] cell_x,
  output logic [CYW-1:0] cell_y,
  output logic           hs_raw,
  output logic           vs_raw,
  output logic           vis,
  output logic           snap
);
  localparam int HV = GRID_W * CELL_PX;
  localparam int VV = GRID_H * CELL_PX;
  localparam int HT = HV + H_FP + H_SYNC + H_BP;
  localparam int VT = VV + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int SW = $clog2(CELL_PX + 1);
  logic pix_en_q, pix_en_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [SW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [CXW-1:0] cx_q, cx_d;
  logic [CYW-1:0] cy_q, cy_d;
  logic h_end, v_end, line, frame_end, h_step, v_step, sx_end, sy_end;
  always_comb begin
    h_end = h_q == HW'(HT - 1);
    v_end = v_q == VW'(VT - 1);
    line = pix_en_q && h_end;
    frame_end = line && v_end;
    h_step = pix_en_q && h_q < HW'(HV - 1);
    v_step = line && v_q < VW'(VV - 1);
    sx_end = sx_q == SW'(CELL_PX - 1);
    sy_end = sy_q == SW'(CELL_PX - 1);
    pix_en_d = !pix_en_q;
    h_d = !pix_en_q ? h_q : h_end ? '0 : h_q + 1'b1;
    v_d = !line ? v_q : v_end ? '0 : v_q + 1'b1;
    sx_d = line ? '0 : h_step ? (sx_end ? '0 : sx_q + 1'b1) : sx_q;
    cx_d = line ? '0 : (h_step && sx_end) ? cx_q + 1'b1 : cx_q;
    sy_d = frame_end ? '0 : v_step ? (sy_end ? '0 : sy_q + 1'b1) : sy_q;
    cy_d = frame_end ? '0 : (v_step && sy_end) ? cy_q + 1'b1 : cy_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_en_q <= 1'b0;
      h_q <= '0;
      v_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      pix_en_q <= pix_en_d;
      h_q <= h_d;
      v_q <= v_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end
  assign pix_en = pix_en_q;
  assign cell_x = cx_q;
  assign cell_y = cy_q;
  assign hs_raw = !(h_q >= HW'(HV + H_FP) && h_q < HW'(HV + H_FP + H_SYNC));
  assign vs_raw = !(v_q >= VW'(VV + V_FP) && v_q < VW'(VV + V_FP + V_SYNC));
  assign vis = h_q < HW'(HV) && v_q < VW'(VV);
  assign snap = pix_en_q && h_q == '0 && v_q == VW'(VV);
endmodule

// File: rtl/vga_grid_renderer.sv
// vga_grid_renderer: clk/reset/grid_flat in; registered vga_r/g/b, vga_hs/vs/de and frame_tick snapshot strobe out
module vga_grid_renderer #(
  parameter int COLOR_W = vga_pkg::COLOR_W,
  parameter int CELL_PX = vga_pkg::CELL_PX,
  parameter int GRID_W = vga_pkg::GRID_W,
  parameter int GRID_H = vga_pkg::GRID_H,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [GRID_W*GRID_H*2-1:0] grid_flat,
  output logic [COLOR_W-1:0]         vga_r,
  output logic [COLOR_W-1:0]         vga_g,
  output logic [COLOR_W-1:0]         vga_b,
  output logic                       vga_hs,
  output logic                       vga_vs,
  output logic                       vga_de,
  output logic                       frame_tick
);
  import vga_pkg::cell_mask;
  localparam int NB = GRID_W * GRID_H * 2;
  localparam int IW = $clog2(NB);
  localparam int CXW = $clog2(GRID_W);
  localparam int CYW = $clog2(GRID_H);
  logic pix_en, hs_raw, vs_raw, vis, snap;
  logic [CXW-1:0] cell_x;
  logic [CYW-1:0] cell_y;
  logic [IW-1:0] idx;
  logic [1:0] code;
  logic [2:0] mask;
  logic [NB-1:0] frame_q, frame_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  vga_timing_gen #(
    .CELL_PX(CELL_PX), .GRID_W(GRID_W), .GRID_H(GRID_H),
    .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .reset(reset), .pix_en(pix_en), .cell_x(cell_x), .cell_y(cell_y),
    .hs_raw(hs_raw), .vs_raw(vs_raw), .vis(vis), .snap(snap)
  );
  always_comb begin
    idx = IW'((int'(cell_y) * GRID_W + int'(cell_x)) * 2);
    code = frame_q[idx +: 2];
    mask = vis ? cell_mask(code) : 3'b000;
    frame_d = snap ? grid_flat : frame_q;
    r_d = pix_en ? {COLOR_W{mask[2]}} : r_q;
    g_d = pix_en ? {COLOR_W{mask[1]}} : g_q;
    b_d = pix_en ? {COLOR_W{mask[0]}} : b_q;
    hs_d = pix_en ? hs_raw : hs_q;
    vs_d = pix_en ? vs_raw : vs_q;
    de_d = pix_en ? vis : de_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      de_q <= 1'b0;
    end else begin
      frame_q <= frame_d;
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
    end
  end
  assign vga_r = r_q;
  assign vga_g = g_q;
  assign vga_b = b_q;
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;
  assign vga_de = de_q;
  assign frame_tick = snap;
endmodule

// File: doc/vga_grid_renderer.md
Name: vga_grid_renderer

Overview:
Downstream consumer of the game controller's flattened 64x48 cell grid (2 bits per cell). It generates 640x480@60 Hz VGA timing from the 50 MHz system clock and scales each cell to 10x10 pixels. It maps the cell codes to RGB output. The grid is snapshotted once per frame at the start of vertical blanking, which makes the output tear-free. A frame tick is provided that the game logic can use as its update strobe.

Parameters:
COLOR_W, 4, bits per colour channel on the DAC outputs
CELL_PX, 10, pixel edge length of one grid cell (fixed by 640/64 = 480/48)
GRID_W, 64, grid columns
GRID_H, 48, grid rows

Ports:
clk  in  1  50 MHz system clock
reset  in  1  synchronous, active-high reset
grid_flat  in  GRID_W*GRID_H*2 (6144)  cell (x,y) at bits [(y*64+x)*2 +: 2]
vga_r  out  COLOR_W  red channel
vga_g  out  COLOR_W  green channel
vga_b  out  COLOR_W  blue channel
vga_hs  out  1  horizontal sync, active low
vga_vs  out  1  vertical sync, active low
vga_de  out  1  active-video flag, aligned with RGB
frame_tick  out  1  one-clk pulse at snapshot instant

Behaviour:
- Pixel enable: pix_en toggles every clk (25 MHz); it is 0 in the first cycle after reset. All counters advance only when pix_en=1.
- h_cnt 0..799: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799. Wraps to 0 and increments v_cnt.
- v_cnt 0..524: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524. Wraps to 0 after h_cnt=799,v_cnt=524.
- No dividers. Cell coordinates come from sub-counters:
  - sub_x 0..9 and cell_x 0..63 step with h_cnt. Both clear at h_cnt wrap.
  - sub_y 0..9 and cell_y 0..47 step on each line wrap. Both clear at v_cnt wrap.
  - cell_x/cell_y hold their last value (63/47) outside the visible area.
- Snapshot: on the pix_en cycle where h_cnt=0 and v_cnt=480, frame_q <= grid_flat and frame_tick=1 for that single clk. At all other times frame_q holds, so grid_flat changes mid-frame have no visible effect.
- Colour map: code = frame_q[(cell_y*64+cell_x)*2 +: 2].
  - 00 black (0,0,0)
  - 01 red (max,0,0)
  - 10 green (0,max,0)
  - 11 blue (0,0,max)
  - max = all COLOR_W bits set.
- Pipeline: one registered stage, updated on pix_en. RGB, vga_hs, vga_vs and vga_de reflect the counter state of the previous pixel tick, so syncs and colour stay aligned. Outside the visible area RGB is forced to 0 and vga_de=0.
- Reset (synchronous, active-high):
  - h_cnt, v_cnt, sub and cell counters = 0
  - frame_q = all zero (black)
  - vga_r/g/b = 0, vga_de = 0, vga_hs = 1, vga_vs = 1, frame_tick = 0, pix_en = 0
- Reset asserted mid-frame: all of the above take effect on the next clk edge. Timing restarts at (0,0) on the first pix_en after release. The first post-reset frame displays black until the first snapshot.
- frame_tick occurs exactly once per 800*525*2 = 840000 clks.

Decomposition:
- Shared package vga_pkg:
  - timing constants H_VIS/H_FP/H_SYNC/H_BP/H_TOTAL and V_*
  - GRID_W, GRID_H, CELL_PX
  - 2-bit cell code localparams CELL_EMPTY=00, CELL_FOOD=01, CELL_SNAKE=10, CELL_WALL=11
- Sub-module vga_timing_gen: pix_en, h/v counters, sub/cell counters, raw sync/visible flags, snapshot strobe.
- The top level owns the frame_q snapshot, the colour lookup and the output register.

Test Plan:
- Reset held 5 clks, then released -> hs=vs=1, de=0, RGB=0 during reset; first hs low 656*2+2 clks after release (±1 pix_en phase); hs period exactly 1600 clks, low width 192 clks.
- Run 2 frames -> vs low for exactly 2 lines (3200 clks) per frame; vs period 840000 clks; frame_tick count=1 per frame, coincident with v_cnt=480, h_cnt=0.
- grid_flat all cells=10 before the first snapshot -> frame 2 visible pixels all vga_g=4'hF, r=b=0; de high for 640 pixels per line, 480 lines.
- Only cell (63,47)=01, others 00 -> red exactly at pixels x 630-639, y 470-479 (100 pixels); all other pixels black.
- Change grid_flat to all 11 at v_cnt=200 of a displayed frame -> rest of that frame unchanged; blue appears from the next frame's line 0.
- Assert reset at v_cnt=300 for 1 clk -> next clk outputs are at reset values; timing restarts at (0,0); screen is black until the following snapshot.
